// File: rtl/ecp5pll_dphase_ctrl_pkg.sv
// ecp5pll_pkg: FSM states, channel/direction constants, per-channel modulus select and shortest-path distance helpers
package ecp5pll_pkg;
  typedef enum logic [2:0] {IDLE, CALC, SETUP, PULSE, GAP, DONE} state_t;
  localparam logic [1:0] CH_CLKOP = 2'd0;
  localparam logic [1:0] CH_CLKOS = 2'd1;
  localparam logic [1:0] CH_CLKOS2 = 2'd2;
  localparam logic [1:0] CH_CLKOS3 = 2'd3;
  localparam logic PHASEDIR_DELAY = 1'b0;
  localparam logic PHASEDIR_ADVANCE = 1'b1;
  function automatic int mod_sel(input logic [1:0] ch, input int m0, input int m1, input int m2, input int m3);
    return ch == CH_CLKOP ? m0 : ch == CH_CLKOS ? m1 : ch == CH_CLKOS2 ? m2 : m3;
  endfunction
  function automatic logic [32:0] mod_dist(input int unsigned target, input int unsigned cur, input int unsigned m);
    int unsigned d;
    d = target >= cur ? target - cur : target + m - cur;
    return d <= m / 2 ? {PHASEDIR_DELAY, d} : {PHASEDIR_ADVANCE, m - d};
  endfunction
endpackage

// File: rtl/ecp5pll_dphase_pos.sv
// ecp5pll_dphase_pos: per-channel phase position file; upd_* steps a channel +/-1 with wrap, cur_ch/cur_pos combinational read, rd_ch/rd_pos registered read
module ecp5pll_dphase_pos
  import ecp5pll_pkg::*;
#(
  parameter int CH_N = 4,
  parameter int POS_W = 10,
  parameter int MOD0 = 64,
  parameter int MOD1 = 64,
  parameter int MOD2 = 64,
  parameter int MOD3 = 64
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             upd_en,
  input  logic [1:0]       upd_ch,
  input  logic             upd_dir,
  input  logic [1:0]       cur_ch,
  output logic [POS_W-1:0] cur_pos,
  input  logic [1:0]       rd_ch,
  output logic [POS_W-1:0] rd_pos
);
  logic [POS_W-1:0] pos_q [CH_N];
  logic [POS_W-1:0] pos_d [CH_N];
  logic [POS_W-1:0] rd_pos_q, rd_pos_d;
  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] p, input logic dir, input int m);
    return dir ? (p == '0 ? POS_W'(m - 1) : p - POS_W'(1)) : (int'(p) == m - 1 ? '0 : p + POS_W'(1));
  endfunction
  always_comb begin
    pos_d = pos_q;
    cur_pos = '0;
    rd_pos_d = '0;
    for (int c = 0; c < CH_N; c++) begin
      if (upd_en && upd_ch == 2'(c)) pos_d[c] = pos_step(pos_q[c], upd_dir, mod_sel(2'(c), MOD0, MOD1, MOD2, MOD3));
      if (cur_ch == 2'(c)) cur_pos = pos_q[c];
      if (rd_ch == 2'(c)) rd_pos_d = pos_q[c];
    end
  end
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CH_N; c++) pos_q[c] <= '0;
      rd_pos_q <= '0;
    end else begin
      pos_q <= pos_d;
      rd_pos_q <= rd_pos_d;
    end
  end
  assign rd_pos = rd_pos_q;
endmodule

// File: rtl/ecp5pll_dphase_ctrl.sv
// ecp5pll_dphase_ctrl: ecp5pll dynamic phase sequencer; req_* request in, rd_ch/rd_pos readback, busy/done/err/lock_err status, locked/clr_err control, phasesel/phasedir/phasestep/phaseloadreg to PLL
module ecp5pll_dphase_ctrl
  import ecp5pll_pkg::*;
#(
  parameter int CH_N = 4,
  parameter int POS_W = 10,
  parameter int MOD0 = 64,
  parameter int MOD1 = 64,
  parameter int MOD2 = 64,
  parameter int MOD3 = 64,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC = 4
) (
  input  logic             clk_i,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_ch,
  input  logic             req_rel,
  input  logic [POS_W-1:0] req_pos,
  input  logic [1:0]       rd_ch,
  output logic [POS_W-1:0] rd_pos,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             lock_err,
  input  logic             clr_err,
  input  logic             locked,
  output logic [1:0]       phasesel,
  output logic             phasedir,
  output logic             phasestep,
  output logic             phaseloadreg
);
  localparam int CW = 16;
  state_t state_q, state_d;
  logic [1:0] ch_q, ch_d, sel_q, sel_d;
  logic rel_q, rel_d, dir_q, dir_d, err_q, err_d, lock_err_q, lock_err_d, lost_q, lost_d;
  logic [POS_W-1:0] val_q, val_d, rem_q, rem_d, cur_pos, calc_steps;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [32:0] md;
  logic accept, reject, pulse_end, lock_set, calc_dir, unused_md;
  int m_req, m_cur;
  assign req_ready = state_q == IDLE && locked && !lock_err_q;
  assign accept = req_valid && req_ready;
  assign m_req = mod_sel(req_ch, MOD0, MOD1, MOD2, MOD3);
  assign m_cur = mod_sel(ch_q, MOD0, MOD1, MOD2, MOD3);
  assign reject = int'(req_ch) >= CH_N || (!req_rel && int'(req_pos) >= m_req);
  assign md = mod_dist(32'(val_q), 32'(cur_pos), 32'(m_cur));
  assign unused_md = ^md[31:POS_W];
  // relative deltas are taken literally; the most-negative value negates to itself, i.e. 2^(POS_W-1) steps back
  assign calc_dir = rel_q ? val_q[POS_W-1] : md[32];
  assign calc_steps = rel_q ? (val_q[POS_W-1] ? -val_q : val_q) : md[POS_W-1:0];
  assign pulse_end = state_q == PULSE && cnt_q == '0;
  // a pulse that sees lock loss runs to its end (and commits its step) before aborting
  assign lock_set = state_q != IDLE && (state_q == PULSE ? pulse_end && (lost_q || !locked) : !locked);
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    rel_d = rel_q;
    val_d = val_q;
    sel_d = sel_q;
    dir_d = dir_q;
    rem_d = rem_q;
    cnt_d = cnt_q - CW'(1);
    lost_d = lost_q;
    err_d = 1'b0;
    lock_err_d = clr_err ? 1'b0 : lock_err_q;
    case (state_q)
      IDLE: if (accept) begin
        ch_d = req_ch;
        rel_d = req_rel;
        val_d = req_pos;
        err_d = reject;
        state_d = reject ? IDLE : CALC;
      end
      CALC: begin
        sel_d = ch_q;
        dir_d = calc_dir;
        rem_d = calc_steps;
        cnt_d = SETUP_CYC == 0 ? CW'(PULSE_CYC - 1) : CW'(SETUP_CYC - 1);
        state_d = calc_steps == '0 ? DONE : SETUP_CYC == 0 ? PULSE : SETUP;
      end
      SETUP: if (cnt_q == '0) begin
        cnt_d = CW'(PULSE_CYC - 1);
        state_d = PULSE;
      end
      PULSE: begin
        lost_d = lost_q || !locked;
        if (cnt_q == '0) begin
          rem_d = rem_q - POS_W'(1);
          cnt_d = CW'(GAP_CYC - 1);
          state_d = GAP;
        end
      end
      GAP: if (cnt_q == '0) begin
        cnt_d = CW'(PULSE_CYC - 1);
        state_d = rem_q != '0 ? PULSE : DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (lock_set) begin
      state_d = IDLE;
      lock_err_d = 1'b1;
      lost_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q <= '0;
      rel_q <= 1'b0;
      val_q <= '0;
      sel_q <= '0;
      dir_q <= 1'b0;
      rem_q <= '0;
      cnt_q <= '0;
      lost_q <= 1'b0;
      err_q <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      rel_q <= rel_d;
      val_q <= val_d;
      sel_q <= sel_d;
      dir_q <= dir_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      lost_q <= lost_d;
      err_q <= err_d;
      lock_err_q <= lock_err_d;
    end
  end
  ecp5pll_dphase_pos #(
    .CH_N(CH_N), .POS_W(POS_W), .MOD0(MOD0), .MOD1(MOD1), .MOD2(MOD2), .MOD3(MOD3)
  ) u_pos (
    .clk_i(clk_i),
    .reset_n(reset_n),
    .upd_en(pulse_end),
    .upd_ch(ch_q),
    .upd_dir(dir_q),
    .cur_ch(ch_q),
    .cur_pos(cur_pos),
    .rd_ch(rd_ch),
    .rd_pos(rd_pos)
  );
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign lock_err = lock_err_q;
  assign phasesel = sel_q;
  assign phasedir = dir_q;
  assign phasestep = state_q == PULSE;
  assign phaseloadreg = 1'b0;
endmodule

// File: tb/tb_ecp5pll_dphase_ctrl.sv
// tb_ecp5pll_dphase_ctrl: table-driven request vectors plus lock-loss, clear/set race and async-reset sequences
module tb_ecp5pll_dphase_ctrl;
  localparam int POS_W = 10;
  logic clk_i = 1'b0, reset_n = 1'b0, req_valid = 1'b0, req_rel = 1'b0, clr_err = 1'b0, locked = 1'b1;
  logic [1:0] req_ch = '0, rd_ch = '0;
  logic [POS_W-1:0] req_pos = '0;
  logic req_ready, busy, done, err, lock_err, phasedir, phasestep, phaseloadreg;
  logic [1:0] phasesel;
  logic [POS_W-1:0] rd_pos;
  always #5 clk_i = ~clk_i;
  ecp5pll_dphase_ctrl #(
    .CH_N(3), .POS_W(POS_W), .MOD0(64), .MOD1(64), .MOD2(64), .MOD3(64),
    .SETUP_CYC(2), .PULSE_CYC(4), .GAP_CYC(4)
  ) dut (
    .clk_i(clk_i), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_rel(req_rel), .req_pos(req_pos), .rd_ch(rd_ch), .rd_pos(rd_pos),
    .busy(busy), .done(done), .err(err), .lock_err(lock_err), .clr_err(clr_err), .locked(locked),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg)
  );
  typedef struct {
    logic [1:0] ch;
    logic rel;
    logic [POS_W-1:0] pos;
    logic e_err;
    int e_pulses;
    logic e_dir;
    int e_pos;
  } vec_t;
  vec_t vt [11];
  int n_vec = 0, n_bad = 0;
  int m_rises, m_first, m_done, m_done_k, m_err, m_err_k, m_badw, m_dirbad, m_selbad, m_both;
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_req(input logic [1:0] ch, input logic rel, input logic [POS_W-1:0] pos, input logic exp_dir, input int drop_at);
    int hi, lo;
    logic prev, fin;
    hi = 0; lo = 0; prev = 1'b0; fin = 1'b0;
    m_rises = 0; m_first = -1; m_done = 0; m_done_k = -1; m_err = 0; m_err_k = -1;
    m_badw = 0; m_dirbad = 0; m_selbad = 0; m_both = 0;
    @(negedge clk_i);
    check("req_ready_before", int'(req_ready), 1);
    req_valid = 1'b1; req_ch = ch; req_rel = rel; req_pos = pos;
    for (int k = 1; k < 6000; k++) begin
      @(negedge clk_i);
      if (k == 1) req_valid = 1'b0;
      if (done) begin m_done++; if (m_done_k < 0) m_done_k = k; end
      if (err) begin m_err++; if (m_err_k < 0) m_err_k = k; end
      if (done && err) m_both++;
      if (phasestep && !prev) begin
        m_rises++;
        if (m_first < 0) m_first = k;
        if (m_rises > 1 && lo != 4) m_badw++;
        if (phasedir !== exp_dir) m_dirbad++;
        if (phasesel !== ch) m_selbad++;
        if (m_rises == drop_at) locked = 1'b0;
      end
      if (!phasestep && prev && hi != 4) m_badw++;
      hi = phasestep ? hi + 1 : 0;
      lo = phasestep ? 0 : lo + 1;
      prev = phasestep;
      if (k >= 2 && !busy && !phasestep) begin fin = 1'b1; break; end
    end
    check("request_finished", int'(fin), 1);
  endtask
  initial begin
    int hcnt;
    vt[0]  = '{2'd1, 1'b0, 10'd5,    1'b0, 5,   1'b0, 5};
    vt[1]  = '{2'd1, 1'b0, 10'd60,   1'b0, 9,   1'b1, 60};
    vt[2]  = '{2'd0, 1'b0, 10'd32,   1'b0, 32,  1'b0, 32};
    vt[3]  = '{2'd0, 1'b1, 10'd0,    1'b0, 0,   1'b0, 32};
    vt[4]  = '{2'd2, 1'b1, 10'd1021, 1'b0, 3,   1'b1, 61};
    vt[5]  = '{2'd1, 1'b0, 10'd64,   1'b1, 0,   1'b0, 60};
    vt[6]  = '{2'd3, 1'b1, 10'd1,    1'b1, 0,   1'b0, 0};
    vt[7]  = '{2'd2, 1'b0, 10'd1,    1'b0, 4,   1'b0, 1};
    vt[8]  = '{2'd1, 1'b1, 10'd10,   1'b0, 10,  1'b0, 6};
    vt[9]  = '{2'd0, 1'b1, 10'h200,  1'b0, 512, 1'b1, 32};
    vt[10] = '{2'd0, 1'b0, 10'd0,    1'b0, 32,  1'b0, 0};
    repeat (3) @(negedge clk_i);
    check("rst_busy", int'(busy), 0);
    check("rst_phasestep", int'(phasestep), 0);
    check("rst_phasesel", int'(phasesel), 0);
    check("rst_phasedir", int'(phasedir), 0);
    check("rst_flags", int'({done, err, lock_err, phaseloadreg}), 0);
    check("rst_rd_pos", int'(rd_pos), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_req(vt[i].ch, vt[i].rel, vt[i].pos, vt[i].e_dir, 0);
      check($sformatf("v%0d_err", i), m_err, vt[i].e_err ? 1 : 0);
      if (vt[i].e_err) check($sformatf("v%0d_err_cycle", i), m_err_k, 1);
      check($sformatf("v%0d_done", i), m_done, vt[i].e_err ? 0 : 1);
      check($sformatf("v%0d_pulses", i), m_rises, vt[i].e_pulses);
      check($sformatf("v%0d_done_err_overlap", i), m_both, 0);
      if (vt[i].e_pulses > 0) begin
        check($sformatf("v%0d_first_rise", i), m_first, 4);
        check($sformatf("v%0d_dir_bad", i), m_dirbad, 0);
        check($sformatf("v%0d_sel_bad", i), m_selbad, 0);
        check($sformatf("v%0d_width_bad", i), m_badw, 0);
      end else if (!vt[i].e_err) check($sformatf("v%0d_done_cycle", i), m_done_k, 2);
      rd_ch = vt[i].ch;
      repeat (2) @(negedge clk_i);
      check($sformatf("v%0d_rd_pos", i), int'(rd_pos), vt[i].e_pos);
    end
    rd_ch = 2'd2;
    run_req(2'd2, 1'b0, 10'd6, 1'b0, 3);
    check("lock_pulses", m_rises, 3);
    check("lock_width_bad", m_badw, 0);
    check("lock_no_done", m_done, 0);
    check("lock_err_set", int'(lock_err), 1);
    check("lock_busy", int'(busy), 0);
    check("lock_rd_pre_update", int'(rd_pos), 3);
    @(negedge clk_i);
    check("lock_rd_post_update", int'(rd_pos), 4);
    hcnt = 0;
    repeat (10) begin @(negedge clk_i); hcnt += int'(phasestep) + int'(done); end
    check("lock_quiet", hcnt, 0);
    check("lock_ready_unlocked", int'(req_ready), 0);
    locked = 1'b1;
    @(negedge clk_i);
    check("lock_ready_sticky", int'(req_ready), 0);
    clr_err = 1'b1;
    @(negedge clk_i);
    clr_err = 1'b0;
    check("lock_err_cleared", int'(lock_err), 0);
    check("lock_ready_back", int'(req_ready), 1);
    clr_err = 1'b1;
    req_valid = 1'b1; req_ch = 2'd2; req_rel = 1'b0; req_pos = 10'd10;
    @(negedge clk_i);
    req_valid = 1'b0;
    @(negedge clk_i);
    locked = 1'b0;
    @(negedge clk_i);
    check("race_set_wins", int'(lock_err), 1);
    check("race_busy", int'(busy), 0);
    @(negedge clk_i);
    check("race_clear_after", int'(lock_err), 0);
    locked = 1'b1; clr_err = 1'b0;
    @(negedge clk_i);
    check("race_rd_pos", int'(rd_pos), 4);
    req_valid = 1'b1; req_ch = 2'd1; req_rel = 1'b0; req_pos = 10'd20;
    @(negedge clk_i);
    req_valid = 1'b0;
    repeat (5) @(negedge clk_i);
    check("arst_pre_phasestep", int'(phasestep), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_phasestep", int'(phasestep), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_phasesel", int'(phasesel), 0);
    @(negedge clk_i);
    reset_n = 1'b1;
    rd_ch = 2'd1;
    repeat (2) @(negedge clk_i);
    check("arst_rd_pos", int'(rd_pos), 0);
    rd_ch = 2'd3;
    repeat (2) @(negedge clk_i);
    check("rd_out_of_range", int'(rd_pos), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
